// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, issue-queue entry layout and the
// tag-match helper used by every wakeup comparator.
package alu_pkg;

  // Operand and tag widths of a stored queue entry.
  localparam int Q_DATA_W = 32;
  localparam int Q_TAG_W  = 5;

  // ALU function codes.
  localparam logic [2:0] F_AND  = 3'd0;
  localparam logic [2:0] F_OR   = 3'd1;
  localparam logic [2:0] F_ADD  = 3'd2;
  localparam logic [2:0] F_XOR  = 3'd3;
  localparam logic [2:0] F_ANDN = 3'd4;
  localparam logic [2:0] F_ORN  = 3'd5;
  localparam logic [2:0] F_SUB  = 3'd6;
  localparam logic [2:0] F_SLT  = 3'd7;

  typedef struct packed {
    logic [Q_DATA_W-1:0] a;
    logic [Q_DATA_W-1:0] b;
    logic                a_rdy;
    logic                b_rdy;
    logic [Q_TAG_W-1:0]  a_tag;
    logic [Q_TAG_W-1:0]  b_tag;
    logic                sign;
    logic [2:0]          f;
    logic [Q_TAG_W-1:0]  dst;
  } entry_t;

  // A waiting operand captures a broadcast whose tag equals its producer tag.
  function automatic logic tag_hit(input logic               rdy,
                                   input logic [Q_TAG_W-1:0] tag,
                                   input logic               wbv,
                                   input logic [Q_TAG_W-1:0] wbt);
    return !rdy && wbv && (tag == wbt);
  endfunction

endpackage

// File: rtl/issue_slot.sv
// One issue-queue entry. Holds an op and wakes its own waiting operands
// when a matching result broadcast arrives. A write replaces the entry
// outright; the writer has already folded in any same-cycle broadcast.
module issue_slot
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               wr_en,
  input  entry_t             wr_ent,
  input  logic               wb_valid,
  input  logic [Q_TAG_W-1:0] wb_tag,
  input  logic [Q_DATA_W-1:0] wb_data,
  output entry_t             ent
);

  // Entry storage: load on write, otherwise per-operand tag-compare wakeup.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ent <= wr_ent;
    end else begin
      if (tag_hit(ent.a_rdy, ent.a_tag, wb_valid, wb_tag)) begin
        ent.a     <= wb_data;
        ent.a_rdy <= 1'b1;
      end
      if (tag_hit(ent.b_rdy, ent.b_tag, wb_valid, wb_tag)) begin
        ent.b     <= wb_data;
        ent.b_rdy <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// In-order operand-wait queue in front of the ALU. Ops wait in a ring of
// issue slots until both operands are present; the oldest then moves into
// the registered ALU-input stage. DATA_W/TAG_W must match the entry layout
// in alu_pkg.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = Q_DATA_W,
  parameter int TAG_W  = Q_TAG_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [DATA_W-1:0]        enq_a,
  input  logic [DATA_W-1:0]        enq_b,
  input  logic                     enq_a_rdy,
  input  logic                     enq_b_rdy,
  input  logic [TAG_W-1:0]         enq_a_tag,
  input  logic [TAG_W-1:0]         enq_b_tag,
  input  logic                     enq_sign,
  input  logic [2:0]               enq_f,
  input  logic [TAG_W-1:0]         enq_dst,
  input  logic                     wb_valid,
  input  logic [TAG_W-1:0]         wb_tag,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [DATA_W-1:0]        iss_a,
  output logic [DATA_W-1:0]        iss_b,
  output logic                     iss_sign,
  output logic [2:0]               iss_f,
  output logic [TAG_W-1:0]         iss_dst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]     cnt_q;
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  entry_t            slot_q [DEPTH];
  entry_t            enq_ent;
  entry_t            head_ent;
  logic              do_enq;
  logic              do_pop;

  logic              vld_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic              sign_p1;
  logic [2:0]        f_p1;
  logic [TAG_W-1:0]  dst_p1;

  assign enq_ready = reset_n && (cnt_q < CW'(DEPTH));
  assign head_ent  = slot_q[head_q];
  assign do_enq    = enq_valid && enq_ready;
  assign do_pop    = (cnt_q != '0) && head_ent.a_rdy && head_ent.b_rdy &&
                     (!vld_p1 || iss_ready);

  // Incoming entry, with a same-cycle broadcast bypassed into waiting operands.
  always_comb begin
    enq_ent       = '0;
    enq_ent.a     = enq_a_rdy ? enq_a : wb_data;
    enq_ent.b     = enq_b_rdy ? enq_b : wb_data;
    enq_ent.a_rdy = enq_a_rdy || tag_hit(enq_a_rdy, enq_a_tag, wb_valid, wb_tag);
    enq_ent.b_rdy = enq_b_rdy || tag_hit(enq_b_rdy, enq_b_tag, wb_valid, wb_tag);
    enq_ent.a_tag = enq_a_tag;
    enq_ent.b_tag = enq_b_tag;
    enq_ent.sign  = enq_sign;
    enq_ent.f     = enq_f;
    enq_ent.dst   = enq_dst;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    issue_slot u_slot (
      .clk      (clk),
      .wr_en    (do_enq && !flush && (tail_q == PW'(i))),
      .wr_ent   (enq_ent),
      .wb_valid (wb_valid),
      .wb_tag   (wb_tag),
      .wb_data  (wb_data),
      .ent      (slot_q[i])
    );
  end

  // Queue control: pointers and occupancy; flush empties the ring.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (do_enq) tail_q <= tail_q + PW'(1);
      if (do_pop) head_q <= head_q + PW'(1);
      case ({do_enq, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---- stage p1: ALU-input register, loaded from the head on pop ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      a_p1    <= '0;
      b_p1    <= '0;
      sign_p1 <= 1'b0;
      f_p1    <= '0;
      dst_p1  <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
    end else if (do_pop) begin
      vld_p1  <= 1'b1;
      a_p1    <= head_ent.a;
      b_p1    <= head_ent.b;
      sign_p1 <= head_ent.sign;
      f_p1    <= head_ent.f;
      dst_p1  <= head_ent.dst;
    end else if (iss_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign iss_valid = vld_p1;
  assign iss_a     = a_p1;
  assign iss_b     = b_p1;
  assign iss_sign  = sign_p1;
  assign iss_f     = f_p1;
  assign iss_dst   = dst_p1;
  assign count     = cnt_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: a directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n, flush, enq_valid, enq_ready;
  logic [31:0] enq_a, enq_b, wb_data, iss_a, iss_b;
  logic        enq_a_rdy, enq_b_rdy, enq_sign, wb_valid, iss_valid, iss_ready, iss_sign;
  logic [4:0]  enq_a_tag, enq_b_tag, enq_dst, wb_tag, iss_dst;
  logic [2:0]  enq_f, iss_f;
  logic [2:0]  count;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(DEPTH), .DATA_W(32), .TAG_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_a(enq_a), .enq_b(enq_b), .enq_a_rdy(enq_a_rdy), .enq_b_rdy(enq_b_rdy),
    .enq_a_tag(enq_a_tag), .enq_b_tag(enq_b_tag),
    .enq_sign(enq_sign), .enq_f(enq_f), .enq_dst(enq_dst),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_a(iss_a), .iss_b(iss_b), .iss_sign(iss_sign), .iss_f(iss_f),
    .iss_dst(iss_dst), .count(count)
  );

  typedef struct {
    bit rst_n, fl, ev, ardy, brdy, sgn, wbv, ir;
    logic [31:0] a, b, wbd;
    logic [4:0]  atag, btag, dst, wbt;
    logic [2:0]  f;
  } in_t;

  typedef struct {
    in_t         in;
    bit          e_vld;
    logic [31:0] e_a, e_b;
    logic [4:0]  e_dst;
    int          e_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] a, b;
    bit          ardy, brdy, sgn;
    logic [4:0]  atag, btag, dst;
    logic [2:0]  f;
  } mop_t;

  mop_t        mq[$];
  bit          m_vld;
  logic [31:0] m_a, m_b;
  bit          m_sgn;
  logic [2:0]  m_f;
  logic [4:0]  m_dst;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t idle();
    in_t r;
    r = '{default: 0};
    r.rst_n = 1; r.ir = 1;
    return r;
  endfunction

  function automatic in_t op(input logic [31:0] a, input bit ardy, input logic [4:0] atag,
                             input logic [31:0] b, input bit brdy, input logic [4:0] btag,
                             input logic [4:0] dst);
    in_t r;
    r = idle();
    r.ev = 1; r.a = a; r.ardy = ardy; r.atag = atag;
    r.b = b; r.brdy = brdy; r.btag = btag; r.f = 3'd2; r.dst = dst;
    return r;
  endfunction

  task automatic apply(input in_t r);
    reset_n = r.rst_n; flush = r.fl; enq_valid = r.ev;
    enq_a = r.a; enq_a_rdy = r.ardy; enq_a_tag = r.atag;
    enq_b = r.b; enq_b_rdy = r.brdy; enq_b_tag = r.btag;
    enq_sign = r.sgn; enq_f = r.f; enq_dst = r.dst;
    wb_valid = r.wbv; wb_tag = r.wbt; wb_data = r.wbd; iss_ready = r.ir;
  endtask

  // One clock: check enq_ready, advance the model, then check state after the edge.
  task automatic cycle();
    bit   en, pop;
    mop_t h, n;
    #1;
    chk("enq_ready", enq_ready, reset_n && (mq.size() < DEPTH));
    if (!reset_n) begin
      mq.delete(); m_vld = 0; m_a = 0; m_b = 0; m_sgn = 0; m_f = 0; m_dst = 0;
    end else if (flush) begin
      mq.delete(); m_vld = 0;
    end else begin
      en  = enq_valid && (mq.size() < DEPTH);
      pop = (mq.size() > 0) && mq[0].ardy && mq[0].brdy && (!m_vld || iss_ready);
      if (pop) begin
        h = mq.pop_front();
        m_vld = 1; m_a = h.a; m_b = h.b; m_sgn = h.sgn; m_f = h.f; m_dst = h.dst;
      end else if (iss_ready) begin
        m_vld = 0;
      end
      if (wb_valid) begin
        foreach (mq[i]) begin
          if (!mq[i].ardy && mq[i].atag == wb_tag) begin mq[i].a = wb_data; mq[i].ardy = 1; end
          if (!mq[i].brdy && mq[i].btag == wb_tag) begin mq[i].b = wb_data; mq[i].brdy = 1; end
        end
      end
      if (en) begin
        n.a = enq_a; n.b = enq_b; n.ardy = enq_a_rdy; n.brdy = enq_b_rdy;
        n.atag = enq_a_tag; n.btag = enq_b_tag; n.sgn = enq_sign; n.f = enq_f; n.dst = enq_dst;
        if (!n.ardy && wb_valid && n.atag == wb_tag) begin n.a = wb_data; n.ardy = 1; end
        if (!n.brdy && wb_valid && n.btag == wb_tag) begin n.b = wb_data; n.brdy = 1; end
        mq.push_back(n);
      end
    end
    @(posedge clk);
    #1;
    chk("iss_valid", iss_valid, m_vld);
    chk("count", count, mq.size());
    if (m_vld) begin
      chk("iss_a", iss_a, m_a);
      chk("iss_b", iss_b, m_b);
      chk("iss_f", iss_f, m_f);
      chk("iss_sign", iss_sign, m_sgn);
      chk("iss_dst", iss_dst, m_dst);
    end
  endtask

  vec_t vt[13];
  in_t  r;

  initial begin
    apply(idle());
    reset_n = 0;
    @(posedge clk); #1;
    cycle(); cycle();
    chk("rst_count", count, 0);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_iss_a", iss_a, 0);
    chk("rst_iss_dst", iss_dst, 0);

    // Directed table: inputs for one cycle, expected state after that edge.
    vt[0]  = '{op(5, 1, 0, 7, 1, 0, 3), 0, 0, 0, 0, 1};
    vt[1]  = '{idle(), 1, 5, 7, 3, 0};
    vt[2]  = '{idle(), 0, 0, 0, 0, 0};
    r = op(1, 1, 0, 0, 0, 4, 5); r.wbv = 1; r.wbt = 4; r.wbd = 32'h10;
    vt[3]  = '{r, 0, 0, 0, 0, 1};
    vt[4]  = '{idle(), 1, 1, 32'h10, 5, 0};
    vt[5]  = '{idle(), 0, 0, 0, 0, 0};
    vt[6]  = '{op(0, 0, 9, 2, 1, 0, 6), 0, 0, 0, 0, 1};
    vt[7]  = '{op(3, 1, 0, 4, 1, 0, 7), 0, 0, 0, 0, 2};
    vt[8]  = '{idle(), 0, 0, 0, 0, 2};
    r = idle(); r.wbv = 1; r.wbt = 9; r.wbd = 32'hDEADBEEF;
    vt[9]  = '{r, 0, 0, 0, 0, 2};
    vt[10] = '{idle(), 1, 32'hDEADBEEF, 2, 6, 1};
    vt[11] = '{idle(), 1, 3, 4, 7, 0};
    vt[12] = '{idle(), 0, 0, 0, 0, 0};
    for (int i = 0; i < 13; i++) begin
      apply(vt[i].in);
      cycle();
      chk($sformatf("vec%0d_valid", i), iss_valid, vt[i].e_vld);
      chk($sformatf("vec%0d_count", i), count, vt[i].e_cnt);
      if (vt[i].e_vld) begin
        chk($sformatf("vec%0d_a", i), iss_a, vt[i].e_a);
        chk($sformatf("vec%0d_b", i), iss_b, vt[i].e_b);
        chk($sformatf("vec%0d_dst", i), iss_dst, vt[i].e_dst);
      end
    end

    // Fill with the ALU stalled, hold, release one cycle, then wrap pointers.
    for (int i = 0; i < 8 && enq_ready; i++) begin
      r = op(32'h100 + i, 1, 0, i, 1, 0, 5'(10 + i)); r.ir = 0;
      apply(r); cycle();
    end
    chk("full_count", count, 4);
    chk("full_enq_ready", enq_ready, 0);
    chk("full_iss_dst", iss_dst, 10);
    r = idle(); r.ir = 0;
    for (int i = 0; i < 3; i++) begin apply(r); cycle(); end
    chk("stall_iss_a", iss_a, 32'h100);
    apply(idle()); cycle();
    chk("one_pop_count", count, 3);
    chk("one_pop_dst", iss_dst, 11);
    for (int i = 0; i < 6; i++) begin
      apply(op(32'h200 + i, 1, 0, i, 1, 0, 5'(20 + i))); cycle();
    end
    for (int i = 0; i < 6; i++) begin apply(idle()); cycle(); end
    chk("wrap_drained", count, 0);

    // Flush with three queued ops, a held issue register and an enqueue.
    for (int i = 0; i < 4; i++) begin
      r = op(i, 1, 0, i, 1, 0, 5'(i)); r.ir = 0; apply(r); cycle();
    end
    chk("pre_flush_count", count, 3);
    chk("pre_flush_valid", iss_valid, 1);
    r = op(32'h55, 1, 0, 1, 1, 0, 9); r.fl = 1; r.ir = 0;
    apply(r); cycle();
    chk("flush_count", count, 0);
    chk("flush_valid", iss_valid, 0);
    apply(idle()); cycle();
    chk("flush_dropped", iss_valid, 0);

    // One-cycle reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      r = op(32'h77, 1, 0, 8, 1, 0, 5'(i)); r.ir = 0; apply(r); cycle();
    end
    r = op(1, 1, 0, 1, 1, 0, 1); r.rst_n = 0;
    apply(r); #1;
    chk("rst_enq_ready_low", enq_ready, 0);
    cycle();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", iss_valid, 0);
    chk("mid_rst_a", iss_a, 0);
    chk("mid_rst_b", iss_b, 0);
    chk("mid_rst_f", iss_f, 0);
    chk("mid_rst_sign", iss_sign, 0);
    chk("mid_rst_dst", iss_dst, 0);
    apply(idle()); #1;
    chk("post_rst_enq_ready", enq_ready, 1);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = idle();
      r.ev   = ($urandom_range(0, 3) != 0);
      r.a    = $urandom; r.b = $urandom;
      r.ardy = ($urandom_range(0, 2) != 0); r.brdy = ($urandom_range(0, 2) != 0);
      r.atag = 5'($urandom_range(0, 7)); r.btag = 5'($urandom_range(0, 7));
      r.sgn  = 1'($urandom); r.f = 3'($urandom); r.dst = 5'($urandom);
      r.wbv  = ($urandom_range(0, 1) != 0);
      r.wbt  = 5'($urandom_range(0, 7)); r.wbd = $urandom;
      r.ir   = ($urandom_range(0, 3) != 0);
      r.fl   = ($urandom_range(0, 63) == 0);
      r.rst_n = ($urandom_range(0, 255) != 0);
      apply(r);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

In-order operand-wait queue directly upstream of the execute-stage ALU. Decoded ALU ops enter with each source either as a value or as a producer tag. Result broadcasts from writeback fill waiting operands. The oldest op is issued into a registered ALU-input stage once both of its operands are present.

## Interface
Parameters:
- DEPTH, 4: queue entries; must be a power of 2, at least 2.
- DATA_W, 32: operand width.
- TAG_W, 5: producer-tag width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  discard all queued ops and the issue register.
- enq_valid  in  1  decoder offers an op.
- enq_ready  out  1  queue can accept an op.
- enq_a, enq_b  in  DATA_W  operand values; meaningful only when the matching _rdy bit is 1.
- enq_a_rdy, enq_b_rdy  in  1  operand value present.
- enq_a_tag, enq_b_tag  in  TAG_W  producer tag; meaningful only when the matching _rdy bit is 0.
- enq_sign  in  1  signed/unsigned select, passed through unchanged.
- enq_f  in  3  ALU function code, passed through unchanged.
- enq_dst  in  TAG_W  destination tag, passed through unchanged.
- wb_valid  in  1  result broadcast valid.
- wb_tag  in  TAG_W  tag of the broadcast result.
- wb_data  in  DATA_W  broadcast result value.
- iss_valid  out  1  ALU-input register holds an op.
- iss_ready  in  1  ALU consumes the op.
- iss_a, iss_b  out  DATA_W  operands to the ALU.
- iss_sign  out  1  to the ALU sign input.
- iss_f  out  3  to the ALU function input.
- iss_dst  out  TAG_W  destination tag carried alongside the ALU result.
- count  out  log2(DEPTH)+1  number of occupied entries; excludes the issue register.

## Operation
- Enqueue:
  - Occurs when enq_valid && enq_ready; the op is written at the tail.
  - enq_ready = !reset_n ? 0 : (count < DEPTH). It does not depend on a same-cycle pop.
- Wakeup:
  - When wb_valid is high, every stored operand with rdy=0 and tag==wb_tag captures wb_data and sets rdy=1 at the clock edge.
  - Multiple entries waiting on the same tag all wake in that same cycle.
  - Operands with rdy=1 ignore broadcasts.
- Enqueue bypass: an enqueuing operand with rdy=0 whose tag matches a same-cycle wb_tag (with wb_valid high) is stored already ready, with value wb_data.
- Issue (pop):
  - Condition: head exists, both head operands rdy=1, and (!iss_valid || iss_ready).
  - On pop, the head loads the issue register and iss_valid is 1 in the next cycle.
  - If the register drains (iss_ready high) without a pop, iss_valid goes to 0.
  - The head's operand rdy bits are sampled before this edge's wakeup; see Timing.
- Ordering: strictly in-order. A non-ready head blocks younger ready ops.
- Stall: while iss_valid && !iss_ready, all iss_* outputs hold stable.
- flush:
  - Dominates enqueue, pop and wakeup. The next cycle has count=0 and iss_valid=0.
  - enq_ready is unaffected by flush itself (it follows count).
- Pointers:
  - head and tail are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is tracked by count; full/empty are taken from count, never from pointer compare.
- Reset: reset_n low at a clock edge sets count=0, both pointers to 0, iss_valid=0, iss_a/iss_b/iss_f/iss_sign/iss_dst=0. This holds mid-operation and discards all state.

## Timing
- Ready op enqueued in cycle N into an empty queue with iss_valid=0: iss_valid=1 in cycle N+2.
- Head waiting on tag T, broadcast in cycle M: rdy set at the end of M, pop at the end of M+1, iss_valid in M+2.
- Throughput: 1 op per cycle sustained when operands are ready and iss_ready=1.
- Simultaneous enqueue and pop: count unchanged.
- Full queue with pop: enq_ready stays 0 that cycle and becomes 1 the next.

## Structure
- Shared package alu_pkg:
  - ALU function constants: F_AND=0, F_OR=1, F_ADD=2, F_XOR=3, F_ANDN=4, F_ORN=5, F_SUB=6, F_SLT=7.
  - Queue entry struct: a, b, a_rdy, b_rdy, a_tag, b_tag, sign, f, dst.
- One sub-module, issue_slot: a single entry holding the struct and doing its own tag-compare wakeup. It is instantiated DEPTH times.
- Pointer/count control and the issue register live in the top module.

## Test plan
- Ready ADD, a=5, b=7, f=2, dst=3, into an empty queue, iss_ready=1 -> iss_valid in cycle +2 with iss_a=5, iss_b=7, iss_f=2, iss_dst=3; count returns to 0.
- Op with a waiting on tag 9, followed by a ready op; broadcast wb_tag=9, wb_data=0xDEAD_BEEF 3 cycles later -> nothing issues before the broadcast; the first op then issues with iss_a=0xDEADBEEF, followed by the second op, in order.
- Enqueue with b_rdy=0, tag 4, in the same cycle as wb_valid, wb_tag=4, wb_data=0x10 -> iss_b=0x10, issued 2 cycles later.
- Fill 4 ready ops with iss_ready=0 -> count=4, enq_ready=0, iss_* stable. Raise iss_ready for 1 cycle -> exactly one op consumed. Pointers wrap across 6 more ops with the order preserved.
- flush asserted with count=3, iss_valid=1, and a concurrent enqueue -> next cycle count=0, iss_valid=0; the concurrent op is dropped.
- reset_n low for 1 cycle mid-stream -> all outputs 0 and count=0; enq_ready=0 during that cycle and 1 after.
